count_rate_ctrl: RTL and testbench

- Run/pause/clear controller that sequences a decimal seconds-style counter display path.
- Generates a selectable-rate one-cycle enable (prescaler), advances a 0-9 digit counter on that enable, and runs a 4-state FSM driven by two debounced-level pushbuttons.
- Sits between board KEY/SW inputs and the 7-segment decoder.
- Replaces the free-running prescaler + enabled-digit pair with a controlled one.

---
 rtl/count_rate_ctrl.sv | 156 +++++++++++++++
 tb/tb_count_rate_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/count_rate_ctrl.sv
// Run/pause/clear sequencer: prescaled one-cycle tick advancing a 0-9 digit, button-driven FSM.
// Latency: button press acts 2 edges after synchronised low; all outputs registered; no backpressure.
module count_rate_ctrl #(
    parameter int TICK_MAX = 49999999,
    parameter int PW       = 28
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        go_n,
    input  logic        clear_n,
    input  logic [1:0]  rate,
    input  logic        one_shot,
    output logic [3:0]  digit,
    output logic        tick,
    output logic        wrap,
    output logic        running,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [PW-1:0] TERM0 = PW'(TICK_MAX);
    localparam logic [PW-1:0] TERM1 = PW'(2 * TICK_MAX + 1);
    localparam logic [PW-1:0] TERM2 = PW'(4 * TICK_MAX + 3);

    state_t        cur_state, nxt_state;
    logic [PW-1:0] presc, presc_nxt;
    logic [1:0]    rate_q, rate_nxt;
    logic [3:0]    digit_nxt;
    logic          tick_nxt, wrap_nxt;

    logic [1:0]    go_sync, clr_sync;
    logic          go_prev, clr_prev;
    logic          go_ev, clr_ev;
    logic [PW-1:0] term;
    logic          term_hit;

    // Buttons idle high, so every stage resets to the released level.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            go_sync  <= 2'b11;
            clr_sync <= 2'b11;
            go_prev  <= 1'b1;
            clr_prev <= 1'b1;
        end else begin
            go_sync  <= {go_sync[0], go_n};
            clr_sync <= {clr_sync[0], clear_n};
            go_prev  <= go_sync[1];
            clr_prev <= clr_sync[1];
        end
    end

    assign go_ev  = go_prev & ~go_sync[1];
    assign clr_ev = clr_prev & ~clr_sync[1];

    always_comb begin
        case (rate_q)
            2'b00:   term = TERM0;
            2'b01:   term = TERM1;
            2'b10:   term = TERM2;
            default: term = '0;
        endcase
    end

    assign term_hit = (presc == term);

    always_comb begin
        nxt_state = cur_state;
        presc_nxt = presc;
        rate_nxt  = rate_q;
        digit_nxt = digit;
        tick_nxt  = 1'b0;
        wrap_nxt  = 1'b0;
        if (clr_ev) begin
            nxt_state = IDLE;
            digit_nxt = 4'd0;
            presc_nxt = '0;
        end else begin
            case (cur_state)
                IDLE: begin
                    if (go_ev) begin
                        nxt_state = RUN;
                        presc_nxt = '0;
                        rate_nxt  = rate;
                    end
                end
                RUN: begin
                    if (term_hit) begin
                        presc_nxt = '0;
                        tick_nxt  = 1'b1;
                        rate_nxt  = rate;
                        if (digit > 4'd9) begin
                            digit_nxt = 4'd0;
                        end else if (one_shot && digit >= 4'd8) begin
                            digit_nxt = 4'd9;
                            nxt_state = DONE;
                        end else if (digit == 4'd9) begin
                            digit_nxt = 4'd0;
                            wrap_nxt  = 1'b1;
                        end else begin
                            digit_nxt = digit + 4'd1;
                        end
                    end else if (!go_ev) begin
                        presc_nxt = presc + 1'b1;
                    end
                    // A pause still lets a coinciding terminal edge complete its update.
                    if (go_ev) begin
                        nxt_state = PAUSE;
                    end
                end
                PAUSE: begin
                    if (go_ev) begin
                        nxt_state = RUN;
                    end
                end
                DONE: begin
                    if (go_ev) begin
                        nxt_state = RUN;
                        digit_nxt = 4'd0;
                        presc_nxt = '0;
                        rate_nxt  = rate;
                    end
                end
                default: nxt_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cur_state <= IDLE;
            presc     <= '0;
            rate_q    <= 2'b00;
            digit     <= 4'd0;
            tick      <= 1'b0;
            wrap      <= 1'b0;
            running   <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            presc     <= presc_nxt;
            rate_q    <= rate_nxt;
            digit     <= digit_nxt;
            tick      <= tick_nxt;
            wrap      <= wrap_nxt;
            running   <= (nxt_state == RUN);
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_count_rate_ctrl.sv
// Randomised button/rate/one_shot stimulus checked every cycle against a period-based reference model.
module tb_count_rate_ctrl;

    localparam int TICK_MAX = 4;
    localparam int PW       = 8;
    localparam int NCYC     = 6000;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_DONE  = 3;

    logic       clk = 1'b0;
    logic       resetn;
    logic       go_n, clear_n;
    logic [1:0] rate;
    logic       one_shot;
    logic [3:0] digit;
    logic       tick, wrap, running;
    logic [1:0] state;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: elapsed clocks within the current period, plus delayed raw button samples.
    int m_state, m_digit, m_elapsed, m_rate, m_tick, m_wrap;
    bit go_q[$];
    bit clr_q[$];

    count_rate_ctrl #(.TICK_MAX(TICK_MAX), .PW(PW)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .go_n     (go_n),
        .clear_n  (clear_n),
        .rate     (rate),
        .one_shot (one_shot),
        .digit    (digit),
        .tick     (tick),
        .wrap     (wrap),
        .running  (running),
        .state    (state)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_state = S_IDLE; m_digit = 0; m_elapsed = 0; m_rate = 0; m_tick = 0; m_wrap = 0;
        go_q  = '{1'b1, 1'b1, 1'b1};
        clr_q = '{1'b1, 1'b1, 1'b1};
    endtask

    // A press counts once its low sample is two edges old and the sample before it was high.
    task automatic model_step();
        bit gev, cev, term;
        int period;
        gev = !go_q[1] && go_q[2];
        cev = !clr_q[1] && clr_q[2];
        go_q.push_front(go_n);
        void'(go_q.pop_back());
        clr_q.push_front(clear_n);
        void'(clr_q.pop_back());
        m_tick = 0;
        m_wrap = 0;
        if (cev) begin
            m_state = S_IDLE; m_digit = 0; m_elapsed = 0;
        end else begin
            case (m_state)
                S_IDLE: if (gev) begin
                    m_state = S_RUN; m_elapsed = 0; m_rate = int'(rate);
                end
                S_RUN: begin
                    period = (m_rate == 3) ? 1 : (TICK_MAX + 1) << m_rate;
                    term = (m_elapsed + 1 == period);
                    if (term) begin
                        m_elapsed = 0;
                        m_tick = 1;
                        m_rate = int'(rate);
                        if (m_digit == 9 && !one_shot) begin
                            m_digit = 0; m_wrap = 1;
                        end else if (one_shot && m_digit >= 8) begin
                            m_digit = 9; m_state = S_DONE;
                        end else begin
                            m_digit = m_digit + 1;
                        end
                    end else if (!gev) begin
                        m_elapsed = m_elapsed + 1;
                    end
                    if (gev) m_state = S_PAUSE;
                end
                S_PAUSE: if (gev) m_state = S_RUN;
                default: if (gev) begin
                    m_state = S_RUN; m_digit = 0; m_elapsed = 0; m_rate = int'(rate);
                end
            endcase
        end
    endtask

    task automatic compare_all(input string pfx);
        check_val({pfx, "_digit"},   int'(digit),   m_digit);
        check_val({pfx, "_tick"},    int'(tick),    m_tick);
        check_val({pfx, "_wrap"},    int'(wrap),    m_wrap);
        check_val({pfx, "_running"}, int'(running), (m_state == S_RUN) ? 1 : 0);
        check_val({pfx, "_state"},   int'(state),   m_state);
    endtask

    task automatic randomize_inputs();
        if (go_n == 1'b0) begin
            if ($urandom_range(2) == 0) go_n = 1'b1;
        end else if ($urandom_range(39) == 0) begin
            go_n = 1'b0;
        end
        if (clear_n == 1'b0) begin
            if ($urandom_range(1) == 0) clear_n = 1'b1;
        end else if ($urandom_range(149) == 0) begin
            clear_n = 1'b0;
        end
        if ($urandom_range(59) == 0) rate = 2'($urandom_range(3));
        if ($urandom_range(99) == 0) one_shot = ~one_shot;
    endtask

    initial begin
        resetn = 1'b0; go_n = 1'b1; clear_n = 1'b1; rate = 2'b00; one_shot = 1'b0;
        model_reset();
        #1;
        compare_all("reset");
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        model_step();
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            compare_all("run");
            if (cyc == NCYC / 2 || cyc == (3 * NCYC) / 4) begin
                // Asynchronous reset between edges must clear outputs without a clock.
                #2;
                resetn = 1'b0; go_n = 1'b1; clear_n = 1'b1;
                #1;
                model_reset();
                compare_all("async_rst");
            end else begin
                resetn = 1'b1;
                randomize_inputs();
                model_step();
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
